// File: rtl/mul_seq_pkg.sv
// Shared types and sizing for the radix-4 sequential multiplier controller.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DIGITS = DEF_WIDTH / 2;

  // Operands are split into 2-bit digits.
  function automatic int num_digits(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/pp_mul2.sv
// Combinational 2-bit x 2-bit unsigned multiplier producing one partial product.
module pp_mul2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);

  assign p = {2'b00, x} * {2'b00, y};

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential multiplier: one 2x2 digit product per cycle, (WIDTH/2)^2 cycles per result,
// valid/ready handshakes on operand and result sides.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int DIGITS = num_digits(WIDTH);
  localparam int CW     = $clog2(DIGITS);
  localparam int AW     = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t          state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]   i_q, j_q;
  logic [AW-1:0]   acc;
  logic [1:0]      a_dig, b_dig;
  logic [3:0]      pp;
  logic [CW:0]     dsum;
  logic [AW-1:0]   pp_sh;
  logic            accept, last_step;

  assign a_dig = a_q[{i_q, 1'b0} +: 2];
  assign b_dig = b_q[{j_q, 1'b0} +: 2];

  pp_mul2 u_pp (
    .x(a_dig),
    .y(b_dig),
    .p(pp)
  );

  // Digit weight is 4^(i+j), i.e. a shift of 2*(i+j) bits.
  assign dsum      = {1'b0, i_q} + {1'b0, j_q};
  assign pp_sh     = AW'(pp) << {dsum, 1'b0};
  assign last_step = (i_q == LAST) && (j_q == LAST);
  assign accept    = (state == IDLE) && start_valid;
  assign result    = acc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    start_ready  = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      i_q <= '0;
      j_q <= '0;
      acc <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
      i_q <= '0;
      j_q <= '0;
      acc <= '0;
    end else if (state == RUN) begin
      acc <= acc + pp_sh;
      // j is the inner (b digit) index, i the outer (a digit) index.
      if (j_q == LAST) begin
        j_q <= '0;
        i_q <= i_q + CW'(1);
      end else begin
        j_q <= j_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl at WIDTH=8 and WIDTH=4: transaction-level model plus directed checks.
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sv[2];
  logic       rr[2];
  logic [7:0] ain[2];
  logic [7:0] bin[2];

  logic        sr8, bz8, rv8;
  logic [15:0] r8;
  logic        sr4, bz4, rv4;
  logic [7:0]  r4;

  mul_seq_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .start_valid(sv[0]), .start_ready(sr8),
    .a(ain[0]), .b(bin[0]),
    .result_valid(rv8), .result_ready(rr[0]),
    .result(r8), .busy(bz8)
  );

  mul_seq_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
    .start_valid(sv[1]), .start_ready(sr4),
    .a(ain[1][3:0]), .b(bin[1][3:0]),
    .result_valid(rv4), .result_ready(rr[1]),
    .result(r4), .busy(bz4)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  function automatic logic o_sr(input int k); return (k != 0) ? sr4 : sr8; endfunction
  function automatic logic o_bz(input int k); return (k != 0) ? bz4 : bz8; endfunction
  function automatic logic o_rv(input int k); return (k != 0) ? rv4 : rv8; endfunction
  function automatic logic [15:0] o_res(input int k);
    return (k != 0) ? {8'h00, r4} : r8;
  endfunction
  function automatic int nsteps(input int k); return (k != 0) ? 4 : 16; endfunction
  function automatic logic [7:0] msk(input int k); return (k != 0) ? 8'h0F : 8'hFF; endfunction

  // Transaction model: 0 = waiting for operands, 1 = computing, 2 = holding a product.
  int          m_phase[2] = '{0, 0};
  int          m_cnt[2]   = '{0, 0};
  logic [15:0] m_pend[2]  = '{16'h0, 16'h0};
  logic [15:0] m_prod[2]  = '{16'h0, 16'h0};
  bit          m_clean[2] = '{1'b1, 1'b1};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_phase[k] <= 0;
        m_clean[k] <= 1'b1;
      end else begin
        case (m_phase[k])
          0: if (sv[k]) begin
            m_phase[k] <= 1;
            m_cnt[k]   <= nsteps(k);
            m_pend[k]  <= 16'(ain[k] & msk(k)) * 16'(bin[k] & msk(k));
            m_clean[k] <= 1'b0;
          end
          1: begin
            m_cnt[k] <= m_cnt[k] - 1;
            if (m_cnt[k] == 1) begin
              m_phase[k] <= 2;
              m_prod[k]  <= m_pend[k];
            end
          end
          default: if (rr[k]) m_phase[k] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("start_ready[%0d]", k), 32'(o_sr(k)), 32'(m_phase[k] == 0));
      chk($sformatf("busy[%0d]", k), 32'(o_bz(k)), 32'(m_phase[k] == 1));
      chk($sformatf("result_valid[%0d]", k), 32'(o_rv(k)), 32'(m_phase[k] == 2));
      if (m_phase[k] == 2)
        chk($sformatf("result[%0d]", k), 32'(o_res(k)), 32'(m_prod[k]));
      else if (m_clean[k])
        chk($sformatf("result_clear[%0d]", k), 32'(o_res(k)), 32'h0);
    end
  end

  // Called at a falling edge; returns at the falling edge just after the acceptance edge.
  task automatic issue(input int k, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    while (!o_sr(k) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("issue_wait", 32'(n), 32'(0));
    sv[k]  = 1'b1;
    ain[k] = x & msk(k);
    bin[k] = y & msk(k);
    @(negedge clk);
    sv[k]  = 1'b0;
    ain[k] = 8'($urandom);
    bin[k] = 8'($urandom);
  endtask

  task automatic wait_done(input int k, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!o_rv(k) && lat < 100) begin
      if (o_bz(k)) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_res(input int k);
    rr[k] = 1'b1;
    @(negedge clk);
    rr[k] = 1'b0;
  endtask

  initial begin
    int lat, bc, n;
    logic [15:0] hold, r;
    logic [7:0] x, y;
    logic v;
    bit done;

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0; rr[k] = 1'b0; ain[k] = 8'h0; bin[k] = 8'h0;
    end
    repeat (2) @(negedge clk);
    chk("rst_start_ready", 32'(sr8), 32'(1));
    chk("rst_busy", 32'(bz8), 32'(0));
    chk("rst_result_valid", 32'(rv8), 32'(0));
    chk("rst_result", 32'(r8), 32'(0));
    chk("rst_result4", 32'(r4), 32'(0));
    rst = 1'b0;

    // basic multiply
    issue(0, 8'd13, 8'd11);
    wait_done(0, lat, bc);
    chk("basic_latency", 32'(lat), 32'd16);
    chk("basic_busy_cycles", 32'(bc), 32'd16);
    chk("basic_result", 32'(r8), 32'd143);
    chk("basic_model", 32'(m_prod[0]), 32'd143);
    release_res(0);
    chk("basic_release_ready", 32'(sr8), 32'(1));
    chk("basic_release_valid", 32'(rv8), 32'(0));

    // maximum and zero operands
    issue(0, 8'hFF, 8'hFF);
    wait_done(0, lat, bc);
    chk("max_latency", 32'(lat), 32'd16);
    chk("max_result", 32'(r8), 32'hFE01);
    release_res(0);
    issue(0, 8'h00, 8'hA5);
    wait_done(0, lat, bc);
    chk("zero_latency", 32'(lat), 32'd16);
    chk("zero_result", 32'(r8), 32'h0);
    release_res(0);

    // backpressure
    issue(0, 8'd37, 8'd91);
    wait_done(0, lat, bc);
    hold = r8;
    chk("bp_value", 32'(hold), 32'd3367);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(rv8), 32'(1));
      chk("bp_result_held", 32'(r8), 32'(hold));
    end
    release_res(0);
    chk("bp_start_ready", 32'(sr8), 32'(1));
    chk("bp_valid_drop", 32'(rv8), 32'(0));

    // start offered while busy
    issue(0, 8'd7, 8'd9);
    repeat (4) begin
      sv[0] = 1'b1; ain[0] = 8'd3; bin[0] = 8'd3;
      @(negedge clk);
      chk("busy_start_ready", 32'(sr8), 32'(0));
    end
    sv[0] = 1'b0;
    wait_done(0, lat, bc);
    chk("busy_latency", 32'(lat), 32'd12);
    chk("busy_result", 32'(r8), 32'd63);
    release_res(0);

    // reset at RUN step 7
    issue(0, 8'd50, 8'd60);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_start_ready", 32'(sr8), 32'(1));
    chk("abort_busy", 32'(bz8), 32'(0));
    chk("abort_valid", 32'(rv8), 32'(0));
    chk("abort_result", 32'(r8), 32'(0));
    issue(0, 8'd200, 8'd100);
    wait_done(0, lat, bc);
    chk("after_abort_latency", 32'(lat), 32'd16);
    chk("after_abort_result", 32'(r8), 32'd20000);
    release_res(0);

    // narrow instance directed
    issue(1, 8'd15, 8'd15);
    wait_done(1, lat, bc);
    chk("w4_latency", 32'(lat), 32'd4);
    chk("w4_result", 32'(r4), 32'd225);
    release_res(1);
    issue(1, 8'd0, 8'd9);
    wait_done(1, lat, bc);
    chk("w4_zero_latency", 32'(lat), 32'd4);
    chk("w4_zero_result", 32'(r4), 32'd0);
    release_res(1);

    // random regression with random result_ready
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 1000; t++) begin
        x = 8'($urandom) & msk(k);
        y = 8'($urandom) & msk(k);
        issue(k, x, y);
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
          rr[k] = 1'($urandom_range(0, 1));
          v = o_rv(k);
          r = o_res(k);
          @(negedge clk);
          if (v && rr[k]) begin
            chk($sformatf("rand_result[%0d] %0d*%0d", k, x, y), 32'(r), 32'(16'(x) * 16'(y)));
            done = 1'b1;
          end
          n++;
        end
        rr[k] = 1'b0;
        if (!done) chk("rand_timeout", 32'(n), 32'(0));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are even and 4..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port start_valid, input, 1 bit: an operand pair is offered.
REQ-005 SHALL have port start_ready, output, 1 bit: the controller can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: unsigned multiplicand.
REQ-007 SHALL have port b, input, WIDTH bits: unsigned multiplier.
REQ-008 SHALL have port result_valid, output, 1 bit: result holds a finished product.
REQ-009 SHALL have port result_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port result, output, 2*WIDTH bits: unsigned product a*b.
REQ-011 SHALL have port busy, output, 1 bit: high while the multiply is in progress.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE, with N = (WIDTH/2)^2 partial-product steps per multiply.
REQ-013 SHALL drive start_ready high only in IDLE, busy high only in RUN, and result_valid high only in DONE.
REQ-014 SHALL accept operands on an edge where start_valid and start_ready are both high: latch a and b, clear the accumulator, reset both digit counters to 0, and go to RUN.
REQ-015 SHALL compute, on each RUN edge, pp = a_digit[i] * b_digit[j] using one shared 2x2 multiplier.
REQ-016 SHALL, on that same edge, add pp shifted left by 2*(i+j) to a 2*WIDTH-bit accumulator, which cannot overflow.
REQ-017 SHALL step j (b digit) as the inner index and i (a digit) as the outer index, each running 0..WIDTH/2-1.
REQ-018 SHALL go to DONE on the edge that adds the last pp (i = j = WIDTH/2-1); result_valid is therefore first high N cycles after the acceptance edge (16 cycles for WIDTH=8).
REQ-019 SHALL perform no early termination: zero or small operands still take exactly N RUN cycles.
REQ-020 SHALL ignore changes on a, b and start_valid while in RUN or DONE.
REQ-021 SHALL hold result stable while result_valid is high and result_ready is low, for any number of cycles.
REQ-022 SHALL go to IDLE on an edge in DONE where result_ready is high; result_valid drops in the next cycle and start_ready rises.
REQ-023 SHALL ignore result_ready when it is asserted outside DONE.
REQ-024 SHALL drive result from the accumulator at all times; it is only meaningful while result_valid is high.

Reset
REQ-025 SHALL, on any edge with rst high, enter IDLE and clear the accumulator, latched operands and counters; this includes rst asserted mid-RUN or in DONE.
REQ-026 SHALL, during and after reset, drive start_ready=1, busy=0, result_valid=0 and result=0.
REQ-027 SHALL produce no result for a multiply aborted by reset.

Structure
REQ-028 SHALL take the state enum (IDLE/RUN/DONE), the default WIDTH and the derived digit count from a shared package mul_seq_pkg.
REQ-029 SHALL place the combinational 2-bit x 2-bit -> 4-bit multiplier in one sub-module, pp_mul2, instantiated exactly once.

Verification
REQ-030 SHALL cover a basic multiply: a=8'd13, b=8'd11 -> result=16'd143, result_valid high exactly 16 cycles after acceptance, busy high for 16 cycles.
REQ-031 SHALL cover maximum operands: a=8'hFF, b=8'hFF -> result=16'hFE01; and a=0, b=8'hA5 -> result=0, still after 16 cycles.
REQ-032 SHALL cover backpressure: result_ready held low 5 cycles after DONE -> result_valid and result stable; on the ready edge -> IDLE, start_ready=1.
REQ-033 SHALL cover start while busy: start_valid with a=3, b=3 during RUN -> ignored; the first product is unaffected and start_ready stays 0.
REQ-034 SHALL cover reset mid-operation: rst for 1 cycle at RUN step 7 -> next cycle IDLE, result=0, result_valid=0; a following 200*100 -> 16'd20000.
REQ-035 SHALL cover random regression: 1000 random pairs at WIDTH=8 and WIDTH=4 with random result_ready -> all results equal a*b.
